// File: rtl/reg_writeback_ctrl.sv
// Write-port arbiter for the 32x32 register bank: ALU results beat load returns,
// and a busy scoreboard of pending load destinations stalls hazardous issue.
module reg_writeback_ctrl #(
    parameter int MAX_LOADS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rs1,
    input  logic [4:0]  iss_rs2,
    input  logic [4:0]  iss_rd,
    input  logic        iss_is_load,
    output logic        iss_ready,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_val,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_val,
    output logic        ld_ready,
    output logic        reg_we,
    output logic [4:0]  rd,
    output logic [31:0] rd_val,
    output logic [31:0] busy
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_LOADS);

    logic [2:0]  count;
    logic        hazard;
    logic        loads_full;
    logic        iss_acc;
    logic        ld_acc;
    logic        cnt_inc;
    logic        cnt_dec;
    logic [31:0] clr_mask;
    logic [31:0] set_mask;

    always_comb begin
        hazard = ((iss_rs1 != 5'd0) && busy[iss_rs1]) ||
                 ((iss_rs2 != 5'd0) && busy[iss_rs2]) ||
                 ((iss_rd  != 5'd0) && busy[iss_rd]);
        loads_full = iss_is_load && (count == MAX_CNT);
        iss_ready  = !(hazard || loads_full);
        ld_ready   = !alu_valid;
        iss_acc    = iss_valid && iss_ready;
        ld_acc     = ld_valid && ld_ready;
        cnt_inc    = iss_acc && iss_is_load;
        // A return with nothing outstanding is still written but must not wrap
        cnt_dec    = ld_acc && (count != 3'd0);
    end

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (ld_acc) begin
            clr_mask[ld_rd] = 1'b1;
        end
        if (cnt_inc && (iss_rd != 5'd0)) begin
            set_mask[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            count <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
            case ({cnt_inc, cnt_dec})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // x0 writes still move rd/rd_val so the bank sees a consistent address/data pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_we <= 1'b0;
            rd     <= '0;
            rd_val <= '0;
        end else if (alu_valid) begin
            reg_we <= (alu_rd != 5'd0);
            rd     <= alu_rd;
            rd_val <= alu_val;
        end else if (ld_valid) begin
            reg_we <= (ld_rd != 5'd0);
            rd     <= ld_rd;
            rd_val <= ld_val;
        end else begin
            reg_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Scoreboard bench for reg_writeback_ctrl: directed scenarios then random traffic,
// checked against a set/queue reference of pending loads and expected writes.
module tb_reg_writeback_ctrl;

    localparam int MAX_LOADS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
    logic        iss_is_load = 1'b0;
    logic        iss_ready;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_val = '0;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_val = '0;
    logic        ld_ready;
    logic        reg_we;
    logic [4:0]  rd;
    logic [31:0] rd_val;
    logic [31:0] busy;

    reg_writeback_ctrl #(.MAX_LOADS(MAX_LOADS)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_is_load(iss_is_load), .iss_ready(iss_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_val(alu_val),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_val(ld_val), .ld_ready(ld_ready),
        .reg_we(reg_we), .rd(rd), .rd_val(rd_val), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference state
    bit          pend[32];
    int          cnt = 0;
    int          lsu_q[$];
    logic [36:0] wr_q[$];
    logic [4:0]  exp_rd = '0;
    logic [31:0] exp_val = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        for (int i = 0; i < 32; i++) b[i] = pend[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        cnt = 0;
        lsu_q.delete();
        wr_q.delete();
        exp_rd = '0;
        exp_val = '0;
    endtask

    // monitor: every write the bank sees must be the oldest expected one
    initial begin
        logic [36:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && reg_we) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", {27'd0, rd}, 32'hFFFF_FFFF);
                end else begin
                    e = wr_q.pop_front();
                    check("write_rd", {27'd0, rd}, {27'd0, e[36:32]});
                    check("write_val", rd_val, e[31:0]);
                end
            end
        end
    end

    task automatic step(input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rdd, input logic il,
                        input logic av, input logic [4:0] ar, input logic [31:0] aval,
                        input logic lv, input logic [4:0] lr, input logic [31:0] lval);
        bit exp_ready;
        @(negedge clk);
        iss_valid = iv; iss_rs1 = r1; iss_rs2 = r2; iss_rd = rdd; iss_is_load = il;
        alu_valid = av; alu_rd = ar; alu_val = aval;
        ld_valid = lv; ld_rd = lr; ld_val = lval;
        #1;
        exp_ready = !((r1 != 0 && pend[r1]) || (r2 != 0 && pend[r2]) ||
                      (rdd != 0 && pend[rdd]) || (il && cnt == MAX_LOADS));
        check("iss_ready", {31'd0, iss_ready}, {31'd0, exp_ready});
        check("ld_ready", {31'd0, ld_ready}, {31'd0, !av});
        if (av) begin
            exp_rd = ar; exp_val = aval;
            if (ar != 0) wr_q.push_back({ar, aval});
        end else if (lv) begin
            exp_rd = lr; exp_val = lval;
            if (lr != 0) wr_q.push_back({lr, lval});
        end
        if (lv && !av) begin
            pend[lr] = 1'b0;
            if (cnt > 0) cnt--;
            for (int i = 0; i < lsu_q.size(); i++)
                if (lsu_q[i] == int'(lr)) begin
                    lsu_q.delete(i);
                    break;
                end
        end
        if (iv && exp_ready && il) begin
            if (rdd != 0) pend[rdd] = 1'b1;
            cnt++;
            lsu_q.push_back(int'(rdd));
        end
        @(posedge clk);
        #1;
        check("busy", busy, model_busy());
        check("rd", {27'd0, rd}, {27'd0, exp_rd});
        check("rd_val", rd_val, exp_val);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic        iv, il, av, lv;
        logic [4:0]  r1, r2, rdd, ar, lr;
        model_reset();

        // reset held with traffic on every input
        rst_n = 1'b0;
        iss_valid = 1; iss_is_load = 1; iss_rd = 5'd9;
        alu_valid = 1; alu_rd = 5'd5; alu_val = 32'hCAFE_F00D;
        ld_valid = 1; ld_rd = 5'd6; ld_val = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_reg_we", {31'd0, reg_we}, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_iss_ready", {31'd0, iss_ready}, 32'd1);
        check("rst_rd_val", rd_val, 32'd0);
        @(negedge clk);
        alu_valid = 0; ld_valid = 0; iss_valid = 0;
        rst_n = 1'b1;

        // ALU write appears one edge later
        step(0, 0, 0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0);
        check("alu_we", {31'd0, reg_we}, 32'd1);
        check("alu_rd", {27'd0, rd}, 32'd5);
        check("alu_val", rd_val, 32'hDEAD_BEEF);

        // RAW stall on pending load to x7
        step(1, 1, 2, 7, 1, 0, 0, 0, 0, 0, 0);
        step(1, 7, 0, 8, 0, 0, 0, 0, 0, 0, 0);
        step(1, 7, 0, 8, 0, 0, 0, 0, 0, 0, 0);
        step(1, 7, 0, 8, 0, 0, 0, 0, 1, 7, 32'h0000_0777);
        check("ld7_we", {31'd0, reg_we}, 32'd1);
        step(1, 7, 0, 8, 0, 0, 0, 0, 0, 0, 0);

        // load count limit
        step(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 2, 6, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 5, 1, 0, 0, 0, 1, 3, 32'h3333_3333);
        step(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);

        // ALU and load collide: ALU first, load next cycle
        step(0, 0, 0, 0, 0, 1, 9, 32'h9999_0000, 1, 4, 32'h4444_4444);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h4444_4444);
        check("ld4_clear", {31'd0, busy[4]}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h5555_5555);

        // x0 destinations
        step(0, 0, 0, 0, 0, 1, 0, 32'h0000_1234, 0, 0, 0);
        check("x0_we", {31'd0, reg_we}, 32'd0);
        check("x0_val", rd_val, 32'h0000_1234);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("x0_busy", busy, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hABCD_0000);
        idle();

        // protocol error: return with nothing outstanding
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 32'h0C0C_0C0C);
        step(1, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 14, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 15, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 32'h1313_1313);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 14, 32'h1414_1414);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            iv  = ($urandom_range(0, 3) != 0);
            r1  = 5'($urandom_range(0, 7));
            r2  = 5'($urandom_range(0, 7));
            rdd = 5'($urandom_range(0, 7));
            il  = ($urandom_range(0, 2) == 0);
            av  = ($urandom_range(0, 3) == 0);
            ar  = 5'($urandom_range(0, 31));
            lv  = 1'b0;
            lr  = '0;
            if (lsu_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                lv = 1'b1;
                lr = 5'(lsu_q[$urandom_range(0, lsu_q.size() - 1)]);
            end
            step(iv, r1, r2, rdd, il, av, ar, $urandom, lv, lr, $urandom);
        end

        // asynchronous reset with loads outstanding
        step(1, 0, 0, 20, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        iss_valid = 0; alu_valid = 0; ld_valid = 0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 32'd0);
        check("mid_rst_we", {31'd0, reg_we}, 32'd0);
        check("mid_rst_rd", {27'd0, rd}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 20, 0, 21, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 22, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 23, 1, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
